// File: rtl/tile_seq.sv
// tile_seq - batch/epoch sequencer for the neural-network tile.
//
// Walks cfg_num_images images for cfg_epochs passes. For each image it fetches
// the image and label, launches the tile in inference or training mode, waits
// for completion and scores the result with a sequential argmax. A per-epoch
// correct count is reported on epoch_valid and the run ends with run_done.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        run request (idle only) / stop run
//   cfg_*               run configuration, captured with start
//   img_req/img_idx     image fetch request and index
//   img_valid/img_label image present on the tile bus, with its label
//   tile_start_fp/_bp   one-cycle launch, inference / training
//   tile_label          label of the image in flight
//   tile_done/result    tile completion and its OUTPUT_SZ signed outputs
//   busy                sequencer not idle
//   epoch_valid/correct end-of-epoch pulse and that epoch's correct count
//   cur_epoch           epoch being processed
//   run_done            all epochs finished
//
// state    | meaning
// S_IDLE   | waiting for start
// S_FETCH  | img_req high, waiting for img_valid
// S_LAUNCH | one-cycle tile launch pulse
// S_WAIT   | waiting for tile_done
// S_SCORE  | argmax walk, one element per cycle
// S_NEXT   | advance image / epoch, epoch_valid at epoch end
// S_FINISH | two cycles; run_done in the second

module tile_seq #(
    parameter int OUTPUT_SZ = 10,
    parameter int IDX_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cfg_train,
    input  logic [IDX_W-1:0]        cfg_num_images,
    input  logic [7:0]              cfg_epochs,
    output logic                    img_req,
    output logic [IDX_W-1:0]        img_idx,
    input  logic                    img_valid,
    input  logic [7:0]              img_label,
    output logic                    tile_start_fp,
    output logic                    tile_start_bp,
    output logic [7:0]              tile_label,
    input  logic                    tile_done,
    input  logic [OUTPUT_SZ*32-1:0] tile_result,
    output logic                    busy,
    output logic                    epoch_valid,
    output logic [IDX_W-1:0]        epoch_correct,
    output logic [7:0]              cur_epoch,
    output logic                    run_done
);

    localparam int K_W = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(OUTPUT_SZ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_SCORE, S_NEXT, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               fin_q, fin_d;
    logic               cfg_train_q, cfg_train_d;
    logic [IDX_W-1:0]   cfg_num_q, cfg_num_d;
    logic [7:0]         cfg_epochs_q, cfg_epochs_d;
    logic [IDX_W-1:0]   img_idx_q, img_idx_d;
    logic [7:0]         cur_epoch_q, cur_epoch_d;
    logic [IDX_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   epoch_correct_q, epoch_correct_d;
    logic [7:0]         tile_label_q, tile_label_d;
    logic signed [31:0] res_q [OUTPUT_SZ];
    logic signed [31:0] res_d [OUTPUT_SZ];
    logic signed [31:0] best_val_q, best_val_d;
    logic [K_W-1:0]     best_idx_q, best_idx_d;
    logic [K_W-1:0]     k_q, k_d;

    logic               last_img;
    logic               last_epoch;
    logic signed [31:0] cand;
    logic               better;
    logic [K_W-1:0]     new_idx;

    assign last_img   = (img_idx_q >= cfg_num_q - IDX_W'(1));
    assign last_epoch = (cur_epoch_q >= cfg_epochs_q - 8'd1);
    assign cand       = res_q[k_q];
    // strict compare keeps the lowest index on ties
    assign better     = (cand > best_val_q);
    assign new_idx    = better ? k_q : best_idx_q;

    always_comb begin
        state_d         = state_q;
        fin_d           = 1'b0;
        cfg_train_d     = cfg_train_q;
        cfg_num_d       = cfg_num_q;
        cfg_epochs_d    = cfg_epochs_q;
        img_idx_d       = img_idx_q;
        cur_epoch_d     = cur_epoch_q;
        acc_d           = acc_q;
        epoch_correct_d = epoch_correct_q;
        tile_label_d    = tile_label_q;
        res_d           = res_q;
        best_val_d      = best_val_q;
        best_idx_d      = best_idx_q;
        k_d             = k_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_train_d  = cfg_train;
                        cfg_num_d    = cfg_num_images;
                        cfg_epochs_d = cfg_epochs;
                        img_idx_d    = '0;
                        cur_epoch_d  = '0;
                        acc_d        = '0;
                        if (cfg_num_images == '0 || cfg_epochs == 8'd0) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (img_valid) begin
                        tile_label_d = img_label;
                        state_d      = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done) begin
                        for (int i = 0; i < OUTPUT_SZ; i++) begin
                            res_d[i] = tile_result[i*32 +: 32];
                        end
                        best_val_d = tile_result[31:0];
                        best_idx_d = '0;
                        k_d        = K_W'(1);
                        state_d    = S_SCORE;
                    end
                end
                S_SCORE: begin
                    if (better) begin
                        best_val_d = cand;
                        best_idx_d = k_q;
                    end
                    k_d = k_q + K_W'(1);
                    if (k_q == LAST_K) begin
                        if (8'(new_idx) == tile_label_q && acc_q != '1) begin
                            acc_d = acc_q + IDX_W'(1);
                        end
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!last_img) begin
                        img_idx_d = img_idx_q + IDX_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        epoch_correct_d = acc_q;
                        acc_d           = '0;
                        img_idx_d       = '0;
                        if (!last_epoch) begin
                            cur_epoch_d = cur_epoch_q + 8'd1;
                            state_d     = S_FETCH;
                        end else begin
                            state_d = S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // first cycle arms, second cycle pulses run_done
                    if (fin_q) begin
                        state_d = S_IDLE;
                    end else begin
                        fin_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            fin_q           <= 1'b0;
            cfg_train_q     <= 1'b0;
            cfg_num_q       <= '0;
            cfg_epochs_q    <= '0;
            img_idx_q       <= '0;
            cur_epoch_q     <= '0;
            acc_q           <= '0;
            epoch_correct_q <= '0;
            tile_label_q    <= '0;
            for (int i = 0; i < OUTPUT_SZ; i++) begin
                res_q[i] <= '0;
            end
            best_val_q      <= '0;
            best_idx_q      <= '0;
            k_q             <= '0;
        end else begin
            state_q         <= state_d;
            fin_q           <= fin_d;
            cfg_train_q     <= cfg_train_d;
            cfg_num_q       <= cfg_num_d;
            cfg_epochs_q    <= cfg_epochs_d;
            img_idx_q       <= img_idx_d;
            cur_epoch_q     <= cur_epoch_d;
            acc_q           <= acc_d;
            epoch_correct_q <= epoch_correct_d;
            tile_label_q    <= tile_label_d;
            res_q           <= res_d;
            best_val_q      <= best_val_d;
            best_idx_q      <= best_idx_d;
            k_q             <= k_d;
        end
    end

    assign img_req       = (state_q == S_FETCH);
    assign img_idx       = img_idx_q;
    assign tile_start_fp = (state_q == S_LAUNCH) && !cfg_train_q;
    assign tile_start_bp = (state_q == S_LAUNCH) && cfg_train_q;
    assign tile_label    = tile_label_q;
    assign busy          = (state_q != S_IDLE);
    assign epoch_valid   = (state_q == S_NEXT) && last_img;
    // the finished count is shown in the pulse cycle itself, then held
    assign epoch_correct = epoch_valid ? acc_q : epoch_correct_q;
    assign cur_epoch     = cur_epoch_q;
    assign run_done      = (state_q == S_FINISH) && fin_q;

endmodule

// File: tb/tb_tile_seq.sv
module tb_tile_seq;

    localparam int OUTPUT_SZ = 10;
    localparam int IDX_W     = 16;
    localparam int RES_W     = OUTPUT_SZ * 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_train = 1'b0;
    logic [IDX_W-1:0] cfg_num_images = '0;
    logic [7:0]       cfg_epochs = '0;
    logic             img_req;
    logic [IDX_W-1:0] img_idx;
    logic             img_valid = 1'b0;
    logic [7:0]       img_label = '0;
    logic             tile_start_fp;
    logic             tile_start_bp;
    logic [7:0]       tile_label;
    logic             tile_done = 1'b0;
    logic [RES_W-1:0] tile_result = '0;
    logic             busy;
    logic             epoch_valid;
    logic [IDX_W-1:0] epoch_correct;
    logic [7:0]       cur_epoch;
    logic             run_done;

    tile_seq #(.OUTPUT_SZ(OUTPUT_SZ), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_train(cfg_train), .cfg_num_images(cfg_num_images), .cfg_epochs(cfg_epochs),
        .img_req(img_req), .img_idx(img_idx), .img_valid(img_valid), .img_label(img_label),
        .tile_start_fp(tile_start_fp), .tile_start_bp(tile_start_bp), .tile_label(tile_label),
        .tile_done(tile_done), .tile_result(tile_result), .busy(busy),
        .epoch_valid(epoch_valid), .epoch_correct(epoch_correct), .cur_epoch(cur_epoch),
        .run_done(run_done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // monitor: counts pulses and records epoch reports / fetch indices
    int   n_fp = 0, n_bp = 0, n_run_done = 0, obs_ep_wr = 0, obs_idx_wr = 0;
    int   obs_cnt [64];
    int   obs_ep  [64];
    int   obs_idx [64];
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (tile_start_fp === 1'b1) n_fp++;
        if (tile_start_bp === 1'b1) n_bp++;
        if (run_done === 1'b1) n_run_done++;
        if (img_req === 1'b1 && req_prev !== 1'b1) begin
            obs_idx[obs_idx_wr % 64] = int'(img_idx);
            obs_idx_wr++;
        end
        req_prev = img_req;
        if (epoch_valid === 1'b1) begin
            obs_cnt[obs_ep_wr % 64] = int'(epoch_correct);
            obs_ep[obs_ep_wr % 64]  = int'(cur_epoch);
            obs_ep_wr++;
        end
    end

    typedef struct { int cnt; int ep; } ep_exp_t;
    ep_exp_t exp_q[$];
    int      exp_idx_q[$];
    int      ep_rd, idx_rd;

    int               lbl_tbl [16];
    logic [RES_W-1:0] res_tbl [16];

    function automatic int ref_argmax(input logic [RES_W-1:0] r);
        int best;
        int bv;
        best = 0;
        bv   = $signed(r[31:0]);
        for (int i = 1; i < OUTPUT_SZ; i++) begin
            if ($signed(r[i*32 +: 32]) > bv) begin
                bv   = $signed(r[i*32 +: 32]);
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [RES_W-1:0] res_peak(input int pk);
        logic [RES_W-1:0] r;
        int v;
        for (int i = 0; i < OUTPUT_SZ; i++) begin
            v = (i == pk) ? 500 : (i * 3 - 20);
            r[i*32 +: 32] = v;
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input bit train, input int num, input int ep);
        cfg_train      = train;
        cfg_num_images = IDX_W'(num);
        cfg_epochs     = 8'(ep);
        start          = 1'b1;
        cyc();
        start          = 1'b0;
    endtask

    // memory + tile responder for one image
    task automatic serve(input logic [7:0] lbl, input logic [RES_W-1:0] res,
                         input int lat, output bit ok);
        int g;
        g = 0;
        while (img_req !== 1'b1 && g < 200) begin
            cyc();
            g++;
        end
        ok = (img_req === 1'b1);
        if (ok) begin
            repeat (lat) cyc();
            img_label = lbl;
            img_valid = 1'b1;
            cyc();
            img_valid = 1'b0;
            repeat (3) cyc();
            tile_result = res;
            tile_done   = 1'b1;
            cyc();
            tile_done   = 1'b0;
        end
    endtask

    task automatic wait_done(input int snap, output bit ok);
        int g;
        g = 0;
        while (n_run_done == snap && g < 1000) begin
            cyc();
            g++;
        end
        ok = (n_run_done != snap);
    endtask

    task automatic run_batch(input bit train, input int num, input int ep,
                             input int lat, output bit ok);
        bit      s_ok;
        int      cnt;
        int      snap;
        ep_exp_t x;
        ok   = 1'b1;
        snap = n_run_done;
        kick(train, num, ep);
        for (int e = 0; e < ep; e++) begin
            cnt = 0;
            for (int i = 0; i < num; i++) begin
                exp_idx_q.push_back(i);
                if (ref_argmax(res_tbl[i]) == lbl_tbl[i]) cnt++;
                serve(8'(lbl_tbl[i]), res_tbl[i], lat, s_ok);
                ok &= s_ok;
            end
            x.cnt = cnt;
            x.ep  = e;
            exp_q.push_back(x);
        end
        wait_done(snap, s_ok);
        ok &= s_ok;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_total++;
        if ({img_req, img_idx, tile_start_fp, tile_start_bp, tile_label, busy,
             epoch_valid, epoch_correct, cur_epoch, run_done} !== '0)
            $display("FAIL reset_outputs: got req=%b idx=%0d fp=%b bp=%b lbl=%0d busy=%b ev=%b ec=%0d ep=%0d rd=%b, want all 0",
                     img_req, img_idx, tile_start_fp, tile_start_bp, tile_label, busy,
                     epoch_valid, epoch_correct, cur_epoch, run_done);
        else n_pass++;
        rst = 1'b0;
        cyc();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_inference();
        bit ok;
        int fp0, bp0, rd0, ev0;
        lbl_tbl[0] = 3; res_tbl[0] = res_peak(3);
        lbl_tbl[1] = 5; res_tbl[1] = res_peak(2);
        lbl_tbl[2] = 7; res_tbl[2] = res_peak(7);
        fp0 = n_fp; bp0 = n_bp; rd0 = n_run_done; ev0 = obs_ep_wr;
        ep_rd = obs_ep_wr; idx_rd = obs_idx_wr;
        run_batch(1'b0, 3, 1, 2, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL infer_timeout: got ok=%b want 1", ok); else n_pass++;
        n_total++;
        if (n_fp - fp0 != 3) $display("FAIL infer_fp_count: got %0d want 3", n_fp - fp0); else n_pass++;
        n_total++;
        if (n_bp - bp0 != 0) $display("FAIL infer_bp_count: got %0d want 0", n_bp - bp0); else n_pass++;
        n_total++;
        if (n_run_done - rd0 != 1) $display("FAIL infer_run_done: got %0d want 1", n_run_done - rd0); else n_pass++;
        n_total++;
        if (obs_ep_wr - ev0 != 1) $display("FAIL infer_epoch_count: got %0d want 1", obs_ep_wr - ev0); else n_pass++;
        while (exp_idx_q.size() != 0) begin
            int xi;
            xi = exp_idx_q.pop_front();
            n_total++;
            if (idx_rd < obs_idx_wr && obs_idx[idx_rd % 64] == xi) n_pass++;
            else $display("FAIL infer_img_idx: got %0d want %0d", obs_idx[idx_rd % 64], xi);
            idx_rd++;
        end
        while (exp_q.size() != 0) begin
            ep_exp_t x;
            x = exp_q.pop_front();
            n_total++;
            if (ep_rd < obs_ep_wr && obs_cnt[ep_rd % 64] == x.cnt && obs_ep[ep_rd % 64] == x.ep) n_pass++;
            else $display("FAIL infer_epoch: got cnt=%0d ep=%0d want cnt=%0d ep=%0d",
                          obs_cnt[ep_rd % 64], obs_ep[ep_rd % 64], x.cnt, x.ep);
            ep_rd++;
        end
        n_total++;
        if (epoch_correct !== 16'd2) $display("FAIL infer_correct_hold: got %0d want 2", epoch_correct); else n_pass++;
    endtask

    task automatic test_training();
        bit ok;
        int fp0, bp0, rd0, ev0;
        lbl_tbl[0] = 1; res_tbl[0] = res_peak(1);
        lbl_tbl[1] = 4; res_tbl[1] = res_peak(4);
        fp0 = n_fp; bp0 = n_bp; rd0 = n_run_done; ev0 = obs_ep_wr;
        ep_rd = obs_ep_wr; idx_rd = obs_idx_wr;
        run_batch(1'b1, 2, 3, 0, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL train_timeout: got ok=%b want 1", ok); else n_pass++;
        n_total++;
        if (n_bp - bp0 != 6) $display("FAIL train_bp_count: got %0d want 6", n_bp - bp0); else n_pass++;
        n_total++;
        if (n_fp - fp0 != 0) $display("FAIL train_fp_count: got %0d want 0", n_fp - fp0); else n_pass++;
        n_total++;
        if (n_run_done - rd0 != 1) $display("FAIL train_run_done: got %0d want 1", n_run_done - rd0); else n_pass++;
        n_total++;
        if (obs_ep_wr - ev0 != 3) $display("FAIL train_epoch_count: got %0d want 3", obs_ep_wr - ev0); else n_pass++;
        while (exp_idx_q.size() != 0) begin
            int xi;
            xi = exp_idx_q.pop_front();
            n_total++;
            if (idx_rd < obs_idx_wr && obs_idx[idx_rd % 64] == xi) n_pass++;
            else $display("FAIL train_img_idx: got %0d want %0d", obs_idx[idx_rd % 64], xi);
            idx_rd++;
        end
        while (exp_q.size() != 0) begin
            ep_exp_t x;
            x = exp_q.pop_front();
            n_total++;
            if (ep_rd < obs_ep_wr && obs_cnt[ep_rd % 64] == x.cnt && obs_ep[ep_rd % 64] == x.ep) n_pass++;
            else $display("FAIL train_epoch: got cnt=%0d ep=%0d want cnt=%0d ep=%0d",
                          obs_cnt[ep_rd % 64], obs_ep[ep_rd % 64], x.cnt, x.ep);
            ep_rd++;
        end
    endtask

    task automatic test_argmax();
        bit ok, all_ok;
        logic [RES_W-1:0] r;
        ep_rd  = obs_ep_wr;
        all_ok = 1'b1;
        for (int i = 0; i < OUTPUT_SZ; i++) r[i*32 +: 32] = 32'(-1);
        r[31:0]   = 32'(-5);
        r[63:32]  = 32'd7;
        r[95:64]  = 32'd7;
        r[127:96] = 32'd3;
        res_tbl[0] = r; lbl_tbl[0] = 1;
        run_batch(1'b0, 1, 1, 1, ok); all_ok &= ok;
        lbl_tbl[0] = 2;
        run_batch(1'b0, 1, 1, 1, ok); all_ok &= ok;
        for (int i = 0; i < OUTPUT_SZ; i++) r[i*32 +: 32] = 32'(-1000 + i * 10);
        res_tbl[0] = r; lbl_tbl[0] = 9;
        run_batch(1'b0, 1, 1, 1, ok); all_ok &= ok;
        n_total++;
        if (all_ok !== 1'b1) $display("FAIL argmax_timeout: got ok=%b want 1", all_ok); else n_pass++;
        while (exp_q.size() != 0) begin
            ep_exp_t x;
            x = exp_q.pop_front();
            n_total++;
            if (ep_rd < obs_ep_wr && obs_cnt[ep_rd % 64] == x.cnt && obs_ep[ep_rd % 64] == x.ep) n_pass++;
            else $display("FAIL argmax_epoch: got cnt=%0d ep=%0d want cnt=%0d ep=%0d",
                          obs_cnt[ep_rd % 64], obs_ep[ep_rd % 64], x.cnt, x.ep);
            ep_rd++;
        end
        exp_idx_q.delete();
    endtask

    task automatic test_zero_config();
        int fp0, bp0, rq0, ev0, rd0;
        fp0 = n_fp; bp0 = n_bp; rq0 = obs_idx_wr; ev0 = obs_ep_wr; rd0 = n_run_done;
        kick(1'b0, 0, 1);
        n_total++;
        if (busy !== 1'b1 || run_done !== 1'b0)
            $display("FAIL zero_t1: got busy=%b run_done=%b want 1 0", busy, run_done);
        else n_pass++;
        cyc();
        n_total++;
        if (busy !== 1'b1 || run_done !== 1'b1)
            $display("FAIL zero_t2: got busy=%b run_done=%b want 1 1", busy, run_done);
        else n_pass++;
        cyc();
        n_total++;
        if (busy !== 1'b0 || run_done !== 1'b0)
            $display("FAIL zero_t3: got busy=%b run_done=%b want 0 0", busy, run_done);
        else n_pass++;
        kick(1'b1, 3, 0);
        repeat (4) cyc();
        n_total++;
        if (n_run_done - rd0 != 2) $display("FAIL zero_run_done: got %0d want 2", n_run_done - rd0); else n_pass++;
        n_total++;
        if (n_fp - fp0 + n_bp - bp0 + obs_idx_wr - rq0 + obs_ep_wr - ev0 != 0)
            $display("FAIL zero_activity: got %0d events want 0", n_fp - fp0 + n_bp - bp0 + obs_idx_wr - rq0 + obs_ep_wr - ev0);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        int fp0, rq0, ev0, rd0;
        fp0 = n_fp; rq0 = obs_idx_wr; ev0 = obs_ep_wr; rd0 = n_run_done;
        kick(1'b0, 4, 1);
        serve(8'd2, res_peak(2), 1, ok);
        ok = 1'b0;
        for (int g = 0; g < 50 && !ok; g++) begin
            if (img_req === 1'b1) ok = 1'b1; else cyc();
        end
        img_label = 8'd4;
        img_valid = 1'b1;
        cyc();
        img_valid = 1'b0;
        repeat (2) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        n_total++;
        if (busy !== 1'b0 || ok !== 1'b1) $display("FAIL abort_busy: got busy=%b reached=%b want 0 1", busy, ok);
        else n_pass++;
        cyc();
        tile_result = res_peak(4);
        tile_done   = 1'b1;
        cyc();
        tile_done   = 1'b0;
        repeat (15) cyc();
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_late_done: got busy=%b want 0", busy); else n_pass++;
        n_total++;
        if (n_run_done - rd0 != 0 || obs_ep_wr - ev0 != 0)
            $display("FAIL abort_no_report: got run_done=%0d epoch=%0d want 0 0", n_run_done - rd0, obs_ep_wr - ev0);
        else n_pass++;
        n_total++;
        if (n_fp - fp0 != 2 || obs_idx_wr - rq0 != 2)
            $display("FAIL abort_activity: got launches=%0d reqs=%0d want 2 2", n_fp - fp0, obs_idx_wr - rq0);
        else n_pass++;
        rd0 = n_run_done;
        kick(1'b0, 1, 1);
        n_total++;
        if (img_req !== 1'b1 || img_idx !== 16'd0)
            $display("FAIL abort_restart: got req=%b idx=%0d want 1 0", img_req, img_idx);
        else n_pass++;
        serve(8'd0, res_peak(0), 0, ok);
        wait_done(rd0, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL abort_restart_done: got ok=%b want 1", ok); else n_pass++;
    endtask

    task automatic test_protocol();
        bit ok, s_ok;
        int fp0, bp0, rd0, ev0, rq0;
        lbl_tbl[0] = 6; res_tbl[0] = res_peak(6);
        lbl_tbl[1] = 8; res_tbl[1] = res_peak(8);
        fp0 = n_fp; bp0 = n_bp; rd0 = n_run_done; ev0 = obs_ep_wr;
        kick(1'b0, 2, 1);
        n_total++;
        if (img_req !== 1'b1) $display("FAIL proto_req_latency: got %b want 1", img_req); else n_pass++;
        cfg_train = 1'b1; cfg_num_images = 16'd5; cfg_epochs = 8'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        serve(8'(lbl_tbl[0]), res_tbl[0], 0, ok);
        serve(8'(lbl_tbl[1]), res_tbl[1], 1, s_ok); ok &= s_ok;
        wait_done(rd0, s_ok); ok &= s_ok;
        n_total++;
        if (ok !== 1'b1 || n_fp - fp0 != 2 || n_bp - bp0 != 0 || obs_ep_wr - ev0 != 1)
            $display("FAIL proto_start_busy: got ok=%b fp=%0d bp=%0d epochs=%0d want 1 2 0 1",
                     ok, n_fp - fp0, n_bp - bp0, obs_ep_wr - ev0);
        else n_pass++;

        fp0 = n_fp; rq0 = obs_idx_wr; rd0 = n_run_done;
        kick(1'b0, 1, 1);
        img_label = 8'd6;
        img_valid = 1'b1;
        repeat (5) cyc();
        img_valid = 1'b0;
        cyc();
        tile_result = res_peak(6);
        tile_done   = 1'b1;
        cyc();
        tile_done   = 1'b0;
        wait_done(rd0, ok);
        n_total++;
        if (ok !== 1'b1 || n_fp - fp0 != 1 || obs_idx_wr - rq0 != 1)
            $display("FAIL proto_valid_held: got ok=%b launches=%0d reqs=%0d want 1 1 1", ok, n_fp - fp0, obs_idx_wr - rq0);
        else n_pass++;
        n_total++;
        if (epoch_correct !== 16'd1) $display("FAIL proto_held_correct: got %0d want 1", epoch_correct); else n_pass++;

        kick(1'b1, 1, 1);
        img_label = 8'd7;
        img_valid = 1'b1;
        cyc();
        img_valid = 1'b0;
        cyc();
        tile_result = res_peak(7);
        tile_done   = 1'b1;
        cyc();
        tile_done   = 1'b0;
        cyc();
        n_total++;
        if (busy !== 1'b1 || tile_label !== 8'd7)
            $display("FAIL proto_pre_rst: got busy=%b label=%0d want 1 7", busy, tile_label);
        else n_pass++;
        rst = 1'b1;
        cyc();
        n_total++;
        if ({img_req, img_idx, tile_start_fp, tile_start_bp, tile_label, busy,
             epoch_valid, epoch_correct, cur_epoch, run_done} !== '0)
            $display("FAIL proto_rst_score: got busy=%b lbl=%0d ec=%0d ep=%0d rd=%b ev=%b want all 0",
                     busy, tile_label, epoch_correct, cur_epoch, run_done, epoch_valid);
        else n_pass++;
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_inference();
        test_training();
        test_argmax();
        test_zero_config();
        test_abort();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
